// File: rtl/sobel_grad_pkg.sv
// Shared constants and FSM encoding for the Sobel gradient stage.
// Address constants assume the default 128x128 frame.
package sobel_grad_pkg;

    localparam int unsigned IMG_W = 128;
    localparam int unsigned AW    = 14;
    localparam int unsigned SAT   = 255;

    localparam logic [AW-1:0] FIRST_ADDR = 14'd129;
    localparam logic [AW-1:0] LAST_ADDR  = 14'd16254;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCap,
        StCalc,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel operator: |Gx| + |Gy| saturated to SAT.
// pRC_i is window row R (0 = top), column C (0 = left).
module sobel_kernel
    import sobel_grad_pkg::*;
#(
    parameter int unsigned SAT = sobel_grad_pkg::SAT
) (
    input  logic [7:0] p00_i,
    input  logic [7:0] p01_i,
    input  logic [7:0] p02_i,
    input  logic [7:0] p10_i,
    input  logic [7:0] p11_i,
    input  logic [7:0] p12_i,
    input  logic [7:0] p20_i,
    input  logic [7:0] p21_i,
    input  logic [7:0] p22_i,
    output logic [7:0] mag_o
);

    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic        [10:0] ax;
    logic        [10:0] ay;
    logic        [11:0] mag;
    logic               unused_centre;

    function automatic logic signed [10:0] ext(input logic [7:0] v);
        return signed'({3'b000, v});
    endfunction

    // The centre tap has zero weight in both kernels.
    assign unused_centre = ^p11_i;

    always_comb begin
        gx = (ext(p02_i) + (ext(p12_i) <<< 1) + ext(p22_i))
           - (ext(p00_i) + (ext(p10_i) <<< 1) + ext(p20_i));
        gy = (ext(p20_i) + (ext(p21_i) <<< 1) + ext(p22_i))
           - (ext(p00_i) + (ext(p01_i) <<< 1) + ext(p02_i));
        ax = gx[10] ? 11'(-gx) : 11'(gx);
        ay = gy[10] ? 11'(-gy) : 11'(gy);
        mag = {1'b0, ax} + {1'b0, ay};
        mag_o = (mag > 12'(SAT)) ? 8'(SAT) : mag[7:0];
    end

endmodule

// File: rtl/sobel_grad.sv
// Sobel gradient stage: walks the interior pixels of the source frame through a 3x3
// window and writes the saturated gradient magnitude of each to the gradient memory.
module sobel_grad
    import sobel_grad_pkg::*;
#(
    parameter int unsigned IMG_W = sobel_grad_pkg::IMG_W,
    parameter int unsigned AW    = sobel_grad_pkg::AW,
    parameter int unsigned SAT   = sobel_grad_pkg::SAT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          s_rd,
    output logic [AW-1:0] s_raddr,
    input  logic [7:0]    s_di,
    output logic          g_wr,
    output logic [AW-1:0] g_waddr,
    output logic [7:0]    g_do,
    output logic          out_valid
);

    localparam int unsigned   CW       = $clog2(IMG_W);
    localparam logic [CW-1:0] LAST_IDX = CW'(IMG_W - 2);

    state_e        state_q, state_d;
    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic [1:0]    rd_row_q, rd_row_d;
    logic [1:0]    rd_col_q, rd_col_d;
    logic          cap_en_q;
    logic [1:0]    cap_row_q;
    logic [1:0]    cap_col_q;
    logic [7:0]    win_q [3][3];
    logic [7:0]    win_d [3][3];
    logic [7:0]    g_do_q, g_do_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    mag;
    logic          win_shift;
    logic [AW-1:0] rd_r;
    logic [AW-1:0] rd_c;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;

    // Window tap being read: row r-1+rd_row, column c-1+rd_col.
    assign rd_r    = AW'(r_q) + AW'(rd_row_q) - AW'(1);
    assign rd_c    = AW'(c_q) + AW'(rd_col_q) - AW'(1);
    assign rd_addr = rd_r * AW'(IMG_W) + rd_c;
    assign wr_addr = AW'(r_q) * AW'(IMG_W) + AW'(c_q);

    sobel_kernel #(
        .SAT (SAT)
    ) u_kernel (
        .p00_i (win_q[0][0]),
        .p01_i (win_q[0][1]),
        .p02_i (win_q[0][2]),
        .p10_i (win_q[1][0]),
        .p11_i (win_q[1][1]),
        .p12_i (win_q[1][2]),
        .p20_i (win_q[2][0]),
        .p21_i (win_q[2][1]),
        .p22_i (win_q[2][2]),
        .mag_o (mag)
    );

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        c_d      = c_q;
        rd_row_d = rd_row_q;
        rd_col_d = rd_col_q;
        g_do_d   = g_do_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d  = StLoad;
                    r_d      = CW'(1);
                    c_d      = CW'(1);
                    rd_row_d = 2'd0;
                    rd_col_d = 2'd0;
                end
            end
            StLoad: begin
                if (rd_row_q == 2'd2) begin
                    rd_row_d = 2'd0;
                    if (rd_col_q == 2'd2) begin
                        state_d = StCap;
                    end else begin
                        rd_col_d = rd_col_q + 2'd1;
                    end
                end else begin
                    rd_row_d = rd_row_q + 2'd1;
                end
            end
            StCap: state_d = StCalc;
            StCalc: begin
                g_do_d  = mag;
                state_d = StWrite;
            end
            StWrite: begin
                if (r_q == LAST_IDX && c_q == LAST_IDX) begin
                    state_d = StDone;
                end else begin
                    state_d  = StLoad;
                    rd_row_d = 2'd0;
                    if (c_q == LAST_IDX) begin
                        c_d      = CW'(1);
                        r_d      = r_q + CW'(1);
                        rd_col_d = 2'd0;
                    end else begin
                        // Window shifts left; only the new right column is fetched.
                        c_d      = c_q + CW'(1);
                        rd_col_d = 2'd2;
                    end
                end
            end
            StDone: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // No read is in flight during WRITE, so the shift never collides with a capture.
    assign win_shift = (state_q == StWrite) && (c_q != LAST_IDX);

    always_comb begin
        win_d = win_q;
        if (win_shift) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
        end
        if (cap_en_q) begin
            win_d[cap_row_q][cap_col_q] = s_di;
        end
    end

    assign out_valid_d = out_valid_q | (state_q == StDone);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            r_q         <= CW'(1);
            c_q         <= CW'(1);
            rd_row_q    <= 2'd0;
            rd_col_q    <= 2'd0;
            cap_en_q    <= 1'b0;
            cap_row_q   <= 2'd0;
            cap_col_q   <= 2'd0;
            g_do_q      <= 8'd0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= 8'd0;
                end
            end
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            cap_en_q    <= s_rd;
            cap_row_q   <= rd_row_q;
            cap_col_q   <= rd_col_q;
            g_do_q      <= g_do_d;
            out_valid_q <= out_valid_d;
            win_q       <= win_d;
        end
    end

    always_comb begin
        s_rd      = (state_q == StLoad);
        s_raddr   = s_rd ? rd_addr : '0;
        g_wr      = (state_q == StWrite);
        g_waddr   = g_wr ? wr_addr : '0;
        g_do      = g_do_q;
        out_valid = out_valid_q;
    end

endmodule

// File: tb/tb_sobel_grad.sv
// Bench for sobel_grad on a reduced 16x16 frame: scoreboard of every gradient write
// against a reference Sobel, spot-value table, latency, handshake and reset-abort checks.
module tb_sobel_grad;

    localparam int W         = 16;
    localparam int AWB       = 14;
    localparam int NPIX      = (W - 2) * (W - 2);
    localparam int FRAME_CYC = (W - 2) * (12 + (W - 3) * 6);

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int    kind;
        int    r;
        int    c;
        int    exp;
        string name;
    } probe_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           s_rd;
    logic [AWB-1:0] s_raddr;
    logic [7:0]     s_di;
    logic           g_wr;
    logic [AWB-1:0] g_waddr;
    logic [7:0]     g_do;
    logic           out_valid;

    logic [7:0] mem [W*W];
    int         got [W*W];
    wr_t        sb_q[$];
    probe_t     probes[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_writes = 0;
    int         first_wr = -1;
    int         last_wr = -1;
    logic       ov_prev = 1'b0;
    logic       rst_edge = 1'b1;

    always #5 clk = ~clk;

    sobel_grad #(
        .IMG_W (W),
        .AW    (AWB),
        .SAT   (255)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .s_rd      (s_rd),
        .s_raddr   (s_raddr),
        .s_di      (s_di),
        .g_wr      (g_wr),
        .g_waddr   (g_waddr),
        .g_do      (g_do),
        .out_valid (out_valid)
    );

    // Source memory: one-cycle read latency.
    always @(posedge clk) begin
        rst_edge <= reset;
        if (s_rd) s_di <= (int'(s_raddr) < W * W) ? mem[s_raddr] : 8'd0;
    end

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic int px(input int r, input int c);
        return int'(mem[r * W + c]);
    endfunction

    function automatic int sobel_ref(input int r, input int c);
        int gx, gy, m;
        gx = (px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1))
           - (px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1));
        gy = (px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1))
           - (px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    always @(negedge clk) begin
        int  a, r, c;
        wr_t e;
        if (s_rd && g_wr) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_wr_overlap: s_rd=%0b g_wr=%0b, required not both 1", s_rd, g_wr);
        end
        if (ov_prev && !out_valid && !rst_edge) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_valid_fell: got 0 without reset, expected 1");
        end
        ov_prev = out_valid;
        if (g_wr) begin
            a = int'(g_waddr);
            r = a / W;
            c = a % W;
            check("border_write", int'(r == 0 || r >= W - 1 || c == 0 || c == W - 1), 0);
            n_writes++;
            if (first_wr < 0) first_wr = a;
            last_wr = a;
            if (a < W * W) got[a] = int'(g_do);
            if (sb_q.size() == 0) begin
                check("unexpected_write_addr", a, -1);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", a, e.addr);
                check("wr_data", int'(g_do), e.data);
            end
        end
    end

    task automatic add_probe(input int kind, input int r, input int c, input int exp,
                             input string name);
        probe_t p;
        p.kind = kind;
        p.r    = r;
        p.c    = c;
        p.exp  = exp;
        p.name = name;
        probes.push_back(p);
    endtask

    task automatic fill_image(input int kind);
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0:       mem[r*W+c] = 8'd100;
                    1:       mem[r*W+c] = (c < W / 2) ? 8'd0 : 8'd255;
                    2:       mem[r*W+c] = 8'(c);
                    default: mem[r*W+c] = (r == 5 && c == 5) ? 8'd255 : 8'd0;
                endcase
            end
        end
    endtask

    task automatic expect_frame();
        sb_q.delete();
        for (int r = 1; r < W - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                sb_q.push_back('{addr: r * W + c, data: sobel_ref(r, c)});
            end
        end
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_s_rd", int'(s_rd), 0);
        check("rst_s_raddr", int'(s_raddr), 0);
        check("rst_g_wr", int'(g_wr), 0);
        check("rst_g_waddr", int'(g_waddr), 0);
        check("rst_g_do", int'(g_do), 0);
        check("rst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_read", int'(s_rd), 0);
    endtask

    task automatic run_frame(input int kind, input bit glitch);
        int n;
        fill_image(kind);
        for (int i = 0; i < W * W; i++) got[i] = -1;
        expect_frame();
        n_writes = 0;
        first_wr = -1;
        last_wr  = -1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("first_rd", int'(s_rd), 1);
        check("first_raddr", int'(s_raddr), 0);
        n = 0;
        while (!out_valid && n < FRAME_CYC + 50) begin
            @(posedge clk);
            n++;
            #1;
            if (glitch && n == 300) in_valid = 1'b1;
            if (glitch && n == 340) in_valid = 1'b0;
        end
        check("out_valid_latency", n, FRAME_CYC + 1);
        check("write_count", n_writes, NPIX);
        check("sb_leftover", sb_q.size(), 0);
        check("first_waddr", first_wr, W + 1);
        check("last_waddr", last_wr, (W - 2) * W + W - 2);
        repeat (5) @(posedge clk);
        #1;
        check("out_valid_hold", int'(out_valid), 1);
        foreach (probes[i]) begin
            if (probes[i].kind == kind) begin
                check(probes[i].name, got[probes[i].r * W + probes[i].c], probes[i].exp);
            end
        end
    endtask

    task automatic abort_frame();
        fill_image(2);
        expect_frame();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (499) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb_q.delete();
        check("abort_s_rd", int'(s_rd), 0);
        check("abort_g_wr", int'(g_wr), 0);
        check("abort_out_valid", int'(out_valid), 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_stays_idle", int'(s_rd) + int'(g_wr), 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        add_probe(0, 1, 1, 0, "uniform_corner");
        add_probe(0, 7, 7, 0, "uniform_mid");
        add_probe(0, 14, 14, 0, "uniform_last");
        add_probe(1, 3, 7, 255, "step_left_edge");
        add_probe(1, 3, 8, 255, "step_right_edge");
        add_probe(1, 3, 6, 0, "step_flat_left");
        add_probe(1, 9, 9, 0, "step_flat_right");
        add_probe(2, 1, 1, 8, "ramp_first");
        add_probe(2, 7, 3, 8, "ramp_mid");
        add_probe(2, 14, 14, 8, "ramp_last");
        add_probe(3, 5, 5, 0, "dot_centre");
        add_probe(3, 4, 4, 255, "dot_nw");
        add_probe(3, 4, 5, 255, "dot_n");
        add_probe(3, 5, 6, 255, "dot_e");
        add_probe(3, 6, 6, 255, "dot_se");
        add_probe(3, 3, 3, 0, "dot_far");
        @(posedge clk);
        #1;
        do_reset();
        run_frame(0, 1'b1);
        do_reset();
        run_frame(1, 1'b0);
        do_reset();
        run_frame(2, 1'b0);
        do_reset();
        run_frame(3, 1'b0);
        do_reset();
        abort_frame();
        run_frame(2, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
